load_store_unit: RTL and testbench

- Memory-stage load/store unit of the 5-stage RV32I pipeline, directly upstream of the write-back select mux.
- Takes the ALU-computed effective address and the store operand. Runs a req/ack transaction on the data-memory bus.
- Extracts and sign/zero-extends load data into `data_memory_output`, which write-back selects when `sel_dm`=01.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory-stage load/store unit with req/ack data bus
// Formats stores onto byte lanes, extends loads, stalls while a bus transaction is in flight.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic [31:0] data_memory_output,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] cnt;

  logic        is_byte, is_half, aligned, timeout_hit;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  // Undefined funct3 encodings fall through to word size.
  always_comb begin
    is_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
    is_half = (funct3 == 3'b001) || (funct3 == 3'b101);
    aligned = is_byte || (is_half && !alu_out[0]) ||
              (!is_byte && !is_half && (alu_out[1:0] == 2'b00));
  end

  always_comb begin
    st_wdata = store_data;
    st_wstrb = 4'b1111;
    if (is_byte) begin
      st_wdata = {4{store_data[7:0]}};
      st_wstrb = 4'b0001 << alu_out[1:0];
    end else if (is_half) begin
      st_wdata = {2{store_data[15:0]}};
      st_wstrb = alu_out[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dbus_rdata[7:0];
      2'd1:    ld_byte = dbus_rdata[15:8];
      2'd2:    ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = dbus_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign lsu_stall   = ((state == IDLE) && mem_valid && aligned) || (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      dbus_req           <= 1'b0;
      dbus_we            <= 1'b0;
      dbus_addr          <= 32'd0;
      dbus_wdata         <= 32'd0;
      dbus_wstrb         <= 4'd0;
      data_memory_output <= 32'd0;
      lsu_done           <= 1'b0;
      misalign_err       <= 1'b0;
      bus_err            <= 1'b0;
      cnt                <= 32'd0;
      f3_q               <= 3'd0;
      off_q              <= 2'd0;
    end else begin
      lsu_done     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid && aligned) begin
            dbus_req   <= 1'b1;
            dbus_we    <= mem_we;
            dbus_addr  <= {alu_out[31:2], 2'b00};
            dbus_wdata <= st_wdata;
            dbus_wstrb <= mem_we ? st_wstrb : 4'd0;
            f3_q       <= funct3;
            off_q      <= alu_out[1:0];
            cnt        <= 32'd0;
            state      <= BUSY;
          end else if (mem_valid) begin
            misalign_err <= 1'b1;
          end
        end
        BUSY: begin
          cnt <= cnt + 32'd1;
          if (dbus_ack) begin
            if (!dbus_we) data_memory_output <= ld_fmt;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_wstrb <= 4'd0;
            lsu_done   <= 1'b1;
            state      <= DONE;
          end else if (timeout_hit) begin
            data_memory_output <= 32'd0;
            bus_err    <= 1'b1;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_wstrb <= 4'd0;
            lsu_done   <= 1'b1;
            state      <= DONE;
          end
        end
        // mem_valid here still belongs to the instruction that just completed.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
// Directed cases followed by random transactions against a lane-arithmetic reference model.
module tb_load_store_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_we;
  logic [2:0]  funct3;
  logic [31:0] alu_out, store_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic [31:0] data_memory_output;
  logic        lsu_stall, lsu_done, misalign_err, bus_err;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_dmo;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we), .funct3(funct3),
    .alu_out(alu_out), .store_data(store_data), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .data_memory_output(data_memory_output),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = acc_size(f3);
    if (n == 4) return rd;
    v = (rd >> (8 * off)) & ((32'd1 << (8 * n)) - 32'd1);
    if (f3[2] == 1'b0 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // delay >= TMO means the ack is withheld and a timeout is expected.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rd, input int delay);
    int n, off;
    bit acked;
    logic [31:0] ew;
    logic [3:0]  es;
    n = acc_size(f3);
    off = int'(addr % 4);
    mem_valid = 1'b1; mem_we = we; funct3 = f3; alu_out = addr; store_data = sd; dbus_rdata = rd;
    @(negedge clk);
    if ((addr % n) != 0) begin
      chk("mis_stall", lsu_stall, 0);
      step();
      mem_valid = 1'b0;
      @(negedge clk);
      chk("mis_err", misalign_err, 1);
      chk("mis_req", dbus_req, 0);
      chk("mis_dmo", data_memory_output, exp_dmo);
      step();
      @(negedge clk);
      chk("mis_err_clr", misalign_err, 0);
      chk("mis_req_after", dbus_req, 0);
      step();
      return;
    end
    chk("start_stall", lsu_stall, 1);
    chk("start_req", dbus_req, 0);
    ew = (n == 1) ? sd[7:0] * 32'h0101_0101 : (n == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    es = 4'(((1 << n) - 1) << off);
    step();
    acked = 0;
    for (int k = 0; k < TMO && !acked; k++) begin
      dbus_ack = (k == delay);
      @(negedge clk);
      chk("busy_req", dbus_req, 1);
      chk("busy_stall", lsu_stall, 1);
      chk("busy_addr", dbus_addr, addr & 32'hFFFF_FFFC);
      chk("busy_we", dbus_we, we);
      if (we) begin
        chk("busy_wdata", dbus_wdata, ew);
        chk("busy_wstrb", dbus_wstrb, es);
      end
      acked = (k == delay);
      step();
    end
    dbus_ack = 1'b0;
    if (!acked) exp_dmo = 32'd0;
    else if (!we) exp_dmo = model_load(f3, off, rd);
    @(negedge clk);
    chk("done_pulse", lsu_done, 1);
    chk("done_stall", lsu_stall, 0);
    chk("done_req", dbus_req, 0);
    chk("done_bus_err", bus_err, acked ? 0 : 1);
    chk("done_dmo", data_memory_output, exp_dmo);
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("idle_done", lsu_done, 0);
    chk("idle_bus_err", bus_err, 0);
    chk("idle_req", dbus_req, 0);
    chk("idle_dmo", data_memory_output, exp_dmo);
    step();
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; funct3 = 3'd0; alu_out = 32'd0;
    store_data = 32'd0; dbus_rdata = 32'd0; dbus_ack = 1'b0; exp_dmo = 32'd0;
    @(negedge clk);
    chk("rst_req", dbus_req, 0);
    chk("rst_we", dbus_we, 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_wdata", dbus_wdata, 0);
    chk("rst_wstrb", dbus_wstrb, 0);
    chk("rst_dmo", data_memory_output, 0);
    chk("rst_stall", lsu_stall, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_mis", misalign_err, 0);
    chk("rst_berr", bus_err, 0);
    step();
    rst = 1'b0;
    step();

    run_txn(1'b0, 3'b000, 32'h103, 32'd0, 32'h80AA5511, 0);
    chk("lb_value", data_memory_output, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b101, 32'h202, 32'd0, 32'hBEEF1234, 1);
    chk("lhu_value", data_memory_output, 32'h0000_BEEF);
    run_txn(1'b1, 3'b000, 32'h41, 32'h123456AB, 32'hFFFF_FFFF, 2);
    chk("sb_dmo_kept", data_memory_output, 32'h0000_BEEF);
    run_txn(1'b0, 3'b010, 32'h06, 32'd0, 32'd0, 0);
    run_txn(1'b0, 3'b010, 32'h10, 32'd0, 32'h1234_5678, 99);
    chk("timeout_dmo", data_memory_output, 32'd0);

    // Reset in the middle of a store with a late ack.
    mem_valid = 1'b1; mem_we = 1'b1; funct3 = 3'b010; alu_out = 32'h80; store_data = 32'hCAFE_F00D;
    step();
    step();
    rst = 1'b1; mem_valid = 1'b0;
    #1;
    chk("rst_mid_req", dbus_req, 0);
    chk("rst_mid_stall", lsu_stall, 0);
    step();
    rst = 1'b0; exp_dmo = 32'd0;
    step();
    dbus_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_done", lsu_done, 0);
    step();
    dbus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_done2", lsu_done, 0);
    chk("late_ack_req", dbus_req, 0);
    step();
    run_txn(1'b0, 3'b010, 32'h84, 32'd0, 32'h600D_BEEF, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int d;
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(acc_size(f3)) - 32'd1);
      d = ($urandom_range(0, 7) == 0) ? 50 : int'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
